// File: rtl/sdram_init_if.sv
// ----------------------------------------------------------------------------
// sdram_init_if
// Bundles the signals between the SDRAM init sequencer and the command
// arbiter that muxes the init commands onto the SDRAM pins.
//   init_req      : single-cycle re-initialisation request (towards sequencer)
//   init_cmd      : {cs_n,ras_n,cas_n,we_n} command during init
//   init_addr     : SDRAM address during init
//   init_ba       : bank address during init (always 0)
//   flag_init_end : high while the init sequence is complete
// master = the sequencer, slave = the arbiter / consumer.
// ----------------------------------------------------------------------------
interface sdram_init_if #(
    parameter int ADDR_W = 13,
    parameter int BA_W   = 2
);
    logic              init_req;
    logic [3:0]        init_cmd;
    logic [ADDR_W-1:0] init_addr;
    logic [BA_W-1:0]   init_ba;
    logic              flag_init_end;

    modport master (
        input  init_req,
        output init_cmd,
        output init_addr,
        output init_ba,
        output flag_init_end
    );

    modport slave (
        output init_req,
        input  init_cmd,
        input  init_addr,
        input  init_ba,
        input  flag_init_end
    );
endinterface

// File: rtl/sdram_init_seq.sv
// ----------------------------------------------------------------------------
// sdram_init_seq
// SDRAM power-up initialisation sequencer:
//   power-up wait -> PRECHARGE ALL -> REF_NUM x AUTO REFRESH -> LOAD MODE
//   -> DONE (flag_init_end=1). A single-cycle init_req in DONE re-runs the
//   sequence from PRECHARGE, skipping the power-up wait.
// Ports:
//   clk      : system clock
//   rst_n    : asynchronous active-low reset
//   init_bus : sdram_init_if.master (init_req in; init_cmd, init_addr,
//              init_ba, flag_init_end out; all outputs registered)
// ----------------------------------------------------------------------------
module sdram_init_seq #(
    parameter int         ADDR_W     = 13,
    parameter int         BA_W       = 2,
    parameter int         DELAY_PWR  = 10000,
    parameter int         T_RP       = 3,
    parameter int         T_RFC      = 7,
    parameter int         T_MRD      = 2,
    parameter int         REF_NUM    = 8,
    parameter logic [2:0] BURST_LEN  = 3'b011,
    parameter logic       BURST_TYPE = 1'b0,
    parameter logic [2:0] CAS_LAT    = 3'b011,
    parameter logic       WR_BURST   = 1'b0
) (
    input  logic         clk,
    input  logic         rst_n,
    sdram_init_if.master init_bus
);

    localparam logic [3:0] CMD_NOP  = 4'b0111;
    localparam logic [3:0] CMD_PRE  = 4'b0010;
    localparam logic [3:0] CMD_AREF = 4'b0001;
    localparam logic [3:0] CMD_MRS  = 4'b0000;

    localparam int MAX_A = (DELAY_PWR > T_RP)  ? DELAY_PWR : T_RP;
    localparam int MAX_B = (T_RFC > T_MRD)     ? T_RFC     : T_MRD;
    localparam int MAX_T = (MAX_A > MAX_B)     ? MAX_A     : MAX_B;
    localparam int CNT_W = $clog2(MAX_T) + 1;

    // Commands are registered from the current state, so every wait state's
    // exit is placed to land the registered command on the intended edge.
    // WAIT_PWR leaves one clock early so PRECHARGE shows after edge DELAY_PWR.
    localparam logic [CNT_W-1:0] PWR_LAST = CNT_W'(DELAY_PWR - 2);
    localparam logic [CNT_W-1:0] RP_LAST  = CNT_W'(T_RP - 1);
    localparam logic [CNT_W-1:0] RFC_LAST = CNT_W'(T_RFC - 1);
    // WAIT_MRD spans T_MRD+1 clocks: flag_init_end is set on entry to DONE,
    // which must be 1+T_MRD edges after MODE_SET becomes visible.
    localparam logic [CNT_W-1:0] MRD_LAST = CNT_W'(T_MRD);

    localparam logic [ADDR_W-1:0] ADDR_PALL = ADDR_W'(1024);
    localparam logic [ADDR_W-1:0] MODE_WORD =
        {{(ADDR_W-10){1'b0}}, WR_BURST, 2'b00, CAS_LAT, BURST_TYPE, BURST_LEN};

    typedef enum logic [2:0] {
        S_WAIT_PWR,
        S_PRE,
        S_WAIT_RP,
        S_REF,
        S_WAIT_RFC,
        S_MRS,
        S_WAIT_MRD,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [7:0]        ref_cnt_q, ref_cnt_d;
    logic [3:0]        cmd_q, cmd_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              flag_q, flag_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_WAIT_PWR;
            cnt_q     <= '0;
            ref_cnt_q <= '0;
            cmd_q     <= CMD_NOP;
            addr_q    <= '0;
            flag_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ref_cnt_q <= ref_cnt_d;
            cmd_q     <= cmd_d;
            addr_q    <= addr_d;
            flag_q    <= flag_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        ref_cnt_d = ref_cnt_q;
        cmd_d     = CMD_NOP;
        addr_d    = '0;

        case (state_q)
            S_WAIT_PWR: if (cnt_q == PWR_LAST) state_d = S_PRE;
            S_PRE: begin
                state_d = S_WAIT_RP;
                cmd_d   = CMD_PRE;
                addr_d  = ADDR_PALL;
            end
            S_WAIT_RP: if (cnt_q == RP_LAST) state_d = S_REF;
            S_REF: begin
                state_d   = S_WAIT_RFC;
                cmd_d     = CMD_AREF;
                ref_cnt_d = ref_cnt_q + 8'd1;
            end
            S_WAIT_RFC: begin
                if (cnt_q == RFC_LAST)
                    state_d = (ref_cnt_q == 8'(REF_NUM)) ? S_MRS : S_REF;
            end
            S_MRS: begin
                state_d = S_WAIT_MRD;
                cmd_d   = CMD_MRS;
                addr_d  = MODE_WORD;
            end
            S_WAIT_MRD: if (cnt_q == MRD_LAST) state_d = S_DONE;
            S_DONE: if (init_bus.init_req) state_d = S_PRE;
            default: state_d = S_WAIT_PWR;
        endcase

        // A new pass (re-init) starts with a fresh refresh count.
        if (state_d == S_PRE) ref_cnt_d = '0;

        // Cleared on every state change and parked at 0 in DONE.
        if (state_d != state_q || state_q == S_DONE)
            cnt_d = '0;
        else
            cnt_d = cnt_q + CNT_W'(1);

        // Looks at the next state so init_req drops the flag on the same edge.
        flag_d = (state_d == S_DONE);
    end

    assign init_bus.init_cmd      = cmd_q;
    assign init_bus.init_addr     = addr_q;
    assign init_bus.init_ba       = '0;
    assign init_bus.flag_init_end = flag_q;

endmodule

// File: tb/tb_sdram_init_seq.sv
// ----------------------------------------------------------------------------
// tb_sdram_init_seq
// Scoreboard bench for sdram_init_seq with default parameters. The stimulus
// process computes the edge number of every command and flag change from the
// sequence timing rules and queues it; a monitor compares each observed
// command / flag change against the head of the queue.
// ----------------------------------------------------------------------------
module tb_sdram_init_seq;

    localparam int ADDR_W    = 13;
    localparam int BA_W      = 2;
    localparam int DELAY_PWR = 10000;
    localparam int T_RP      = 3;
    localparam int T_RFC     = 7;
    localparam int T_MRD     = 2;
    localparam int REF_NUM   = 8;

    localparam logic [3:0] NOP  = 4'b0111;
    localparam logic [3:0] PREC = 4'b0010;
    localparam logic [3:0] AREF = 4'b0001;
    localparam logic [3:0] MSET = 4'b0000;
    localparam logic [ADDR_W-1:0] A_PALL = 13'h400;
    localparam logic [ADDR_W-1:0] A_MODE = 13'h033;

    typedef struct {
        int                e_edge;
        bit                is_flag;
        logic [3:0]        cmd;
        logic [ADDR_W-1:0] addr;
        logic              flag;
    } ev_t;

    logic clk;
    logic rst_n;
    int   checks   = 0;
    int   failures = 0;
    int   edge_cnt;
    bit   mon_en   = 0;
    ev_t  exp_q[$];

    sdram_init_if #(.ADDR_W(ADDR_W), .BA_W(BA_W)) bus ();

    sdram_init_seq #(
        .ADDR_W(ADDR_W), .BA_W(BA_W), .DELAY_PWR(DELAY_PWR),
        .T_RP(T_RP), .T_RFC(T_RFC), .T_MRD(T_MRD), .REF_NUM(REF_NUM),
        .BURST_LEN(3'b011), .BURST_TYPE(1'b0), .CAS_LAT(3'b011),
        .WR_BURST(1'b0)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .init_bus(bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Edge 1 is the first rising edge after rst_n deasserts.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) edge_cnt <= 0;
        else        edge_cnt <= edge_cnt + 1;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached at edge %0d", edge_cnt);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    task automatic push_cmd(input int e, input logic [3:0] c, input logic [ADDR_W-1:0] a);
        ev_t ev;
        ev.e_edge = e; ev.is_flag = 1'b0; ev.cmd = c; ev.addr = a; ev.flag = 1'b0;
        exp_q.push_back(ev);
    endtask

    task automatic push_flag(input int e, input logic v);
        ev_t ev;
        ev.e_edge = e; ev.is_flag = 1'b1; ev.cmd = NOP; ev.addr = '0; ev.flag = v;
        exp_q.push_back(ev);
    endtask

    // Queue one full pass whose PRECHARGE is visible after edge pre_e.
    task automatic push_seq(input int pre_e, output int done_e);
        int r0, m;
        push_cmd(pre_e, PREC, A_PALL);
        r0 = pre_e + 1 + T_RP;
        for (int k = 0; k < REF_NUM; k++)
            push_cmd(r0 + k * (1 + T_RFC), AREF, '0);
        m = r0 + REF_NUM * (1 + T_RFC);
        push_cmd(m, MSET, A_MODE);
        done_e = m + 1 + T_MRD;
        push_flag(done_e, 1'b1);
    endtask

    // Leaves the caller at the falling edge following edge 'target'.
    task automatic wait_edge(input int target);
        int budget;
        budget = target - edge_cnt + 10;
        while (edge_cnt < target && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        if (edge_cnt != target) begin
            checks++; failures++;
            $display("FAIL wait_edge: reached edge %0d, required edge %0d", edge_cnt, target);
        end
    endtask

    // init_req high for exactly the clock that ends at edge e.
    task automatic pulse_req(input int e);
        wait_edge(e - 1);
        bus.init_req = 1'b1;
        @(negedge clk);
        bus.init_req = 1'b0;
    endtask

    // Monitor / scoreboard.
    initial begin
        logic flag_prev;
        bit   is_cmd, is_fl, ok;
        ev_t  ev;
        flag_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n && mon_en) begin
                while (exp_q.size() > 0 && exp_q[0].e_edge < edge_cnt) begin
                    ev = exp_q.pop_front();
                    checks++; failures++;
                    $display("FAIL missed_event: at edge %0d nothing seen, required cmd=%h addr=%h flag_evt=%0d at edge %0d",
                             edge_cnt, ev.cmd, ev.addr, ev.is_flag, ev.e_edge);
                end
                is_cmd = (bus.init_cmd != NOP);
                is_fl  = (bus.flag_init_end != flag_prev);
                if (is_cmd || is_fl) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        failures++;
                        $display("FAIL unexpected_output: edge %0d cmd=%h addr=%h flag=%0d, required nothing",
                                 edge_cnt, bus.init_cmd, bus.init_addr, bus.flag_init_end);
                    end else begin
                        ev = exp_q.pop_front();
                        ok = (ev.e_edge == edge_cnt);
                        if (ev.is_flag)
                            ok = ok && is_fl && !is_cmd && (bus.flag_init_end == ev.flag);
                        else
                            ok = ok && is_cmd && !is_fl && (bus.init_cmd == ev.cmd) &&
                                 (bus.init_addr == ev.addr);
                        if (!ok) begin
                            failures++;
                            $display("FAIL event: actual edge=%0d cmd=%h addr=%h flag=%0d; required edge=%0d cmd=%h addr=%h flag_evt=%0d flag=%0d",
                                     edge_cnt, bus.init_cmd, bus.init_addr, bus.flag_init_end,
                                     ev.e_edge, ev.cmd, ev.addr, ev.is_flag, ev.flag);
                        end
                    end
                end else begin
                    checks++;
                    if (bus.init_addr != '0) begin
                        failures++;
                        $display("FAIL nop_addr: edge %0d actual addr=%h required 0", edge_cnt, bus.init_addr);
                    end
                end
                checks++;
                if (bus.init_ba != '0) begin
                    failures++;
                    $display("FAIL ba: edge %0d actual ba=%h required 0", edge_cnt, bus.init_ba);
                end
                flag_prev = bus.flag_init_end;
            end else begin
                flag_prev = 1'b0;
            end
        end
    end

    task automatic check_reset_vals(input string tag);
        check({tag, "_cmd"},  int'(bus.init_cmd),      int'(NOP));
        check({tag, "_addr"}, int'(bus.init_addr),     0);
        check({tag, "_ba"},   int'(bus.init_ba),       0);
        check({tag, "_flag"}, int'(bus.flag_init_end), 0);
    endtask

    initial begin
        int done_e, n, p, k, r0;
        rst_n        = 1'b0;
        bus.init_req = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_vals("reset");

        // Power-up sequence with ignored requests in WAIT_PWR and WAIT_RFC.
        rst_n = 1'b1;
        push_seq(DELAY_PWR, done_e);
        mon_en = 1'b1;
        p = int'($urandom_range(2, DELAY_PWR - 10));
        pulse_req(p);
        r0 = DELAY_PWR + 1 + T_RP;
        k  = int'($urandom_range(0, REF_NUM - 1));
        p  = r0 + k * (1 + T_RFC) + int'($urandom_range(1, T_RFC));
        pulse_req(p);
        wait_edge(done_e);
        check("powerup_done_flag", int'(bus.flag_init_end), 1);

        // Software re-init from DONE.
        n = done_e + int'($urandom_range(1, 10));
        wait_edge(n - 1);
        push_flag(n, 1'b0);
        push_seq(n + 1, done_e);
        bus.init_req = 1'b1;
        @(negedge clk);
        bus.init_req = 1'b0;
        check("reinit_flag_clear", int'(bus.flag_init_end), 0);
        wait_edge(done_e);
        check("reinit_done_edge", done_e, n + 1 + 71);

        // init_req held high: one restart per visit to DONE.
        bus.init_req = 1'b1;
        for (int pass = 0; pass < 3; pass++) begin
            n = done_e + 1;
            push_flag(n, 1'b0);
            push_seq(n + 1, done_e);
            wait_edge(done_e);
            check("hold_done_flag", int'(bus.flag_init_end), 1);
        end
        bus.init_req = 1'b0;
        repeat (5) @(negedge clk);
        check("hold_queue_empty", exp_q.size(), 0);
        check("hold_flag_stays", int'(bus.flag_init_end), 1);

        // Asynchronous reset from DONE forces outputs immediately.
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_vals("rst_done");
        exp_q.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        push_seq(DELAY_PWR, done_e);

        // Reset mid-refresh, on a clock that carries AUTO_REF.
        wait_edge(DELAY_PWR + 1 + T_RP + 3 * (1 + T_RFC));
        #2;
        check("midseq_cmd_before", int'(bus.init_cmd), int'(AREF));
        rst_n = 1'b0;
        #1;
        check_reset_vals("rst_mid");
        exp_q.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        push_seq(DELAY_PWR, done_e);
        wait_edge(done_e);
        repeat (5) @(negedge clk);
        check("final_queue_empty", exp_q.size(), 0);
        check("final_flag", int'(bus.flag_init_end), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
